// File: rtl/path_delay_and.sv
// Clocked AND-reduction with a run-time programmable per-input delay line.
// out_valid marks when every tap reflects history from after the last reset or delay write.
module path_delay_and #(
    parameter int N_IN    = 4,
    parameter int MAX_DLY = 16,
    parameter int DLY_LO  = 9,
    parameter int DLY_HI  = 11
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_IN-1:0]                in,
    input  logic                           cfg_we,
    input  logic [$clog2(N_IN)-1:0]        cfg_idx,
    input  logic [$clog2(MAX_DLY+1)-1:0]   cfg_dly,
    output logic                           out,
    output logic                           out_valid,
    output logic                           cfg_err
);

    localparam int DW    = $clog2(MAX_DLY + 1);
    localparam int IW    = $clog2(N_IN);
    localparam int M_RST = (DLY_LO > DLY_HI) ? DLY_LO : DLY_HI;

    localparam logic [DW-1:0] MAX_W  = DW'(MAX_DLY);
    localparam logic [IW:0]   N_IN_W = (IW + 1)'(N_IN);

    logic [MAX_DLY-1:0] sr_q   [N_IN];
    logic [MAX_DLY-1:0] sr_d   [N_IN];
    logic [DW-1:0]      dly_q  [N_IN];
    logic [DW-1:0]      dly_d  [N_IN];
    logic [DW-1:0]      scnt_q;
    logic [DW-1:0]      scnt_d;
    logic               cfg_err_q;
    logic               cfg_err_d;

    logic [DW-1:0]      clamped;
    logic [DW-1:0]      dly_max;
    logic               idx_ok;
    logic               wr_ok;
    logic [N_IN-1:0]    tap;

    always_comb begin
        clamped = cfg_dly;
        if (cfg_dly == '0) begin
            clamped = DW'(1);
        end else if (cfg_dly > MAX_W) begin
            clamped = MAX_W;
        end
        idx_ok = ({1'b0, cfg_idx} < N_IN_W);
        wr_ok  = cfg_we && idx_ok;
    end

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            sr_d[i]  = {sr_q[i][MAX_DLY-2:0], in[i]};
            dly_d[i] = dly_q[i];
            if (wr_ok && (cfg_idx == IW'(i))) begin
                dly_d[i] = clamped;
            end
        end

        // Settle time is set by the longest delay in the post-write set.
        dly_max = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (dly_d[i] > dly_max) begin
                dly_max = dly_d[i];
            end
        end

        cfg_err_d = cfg_we && !idx_ok;

        if (wr_ok) begin
            scnt_d = dly_max - 1'b1;
        end else if (scnt_q != '0) begin
            scnt_d = scnt_q - 1'b1;
        end else begin
            scnt_d = scnt_q;
        end
    end

    // Reset loads M rather than M-1 so that edge 0, the first sampled input, counts like a write edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_IN; i++) begin
                sr_q[i]  <= '0;
                dly_q[i] <= (i < N_IN / 2) ? DW'(DLY_LO) : DW'(DLY_HI);
            end
            scnt_q    <= DW'(M_RST);
            cfg_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                sr_q[i]  <= sr_d[i];
                dly_q[i] <= dly_d[i];
            end
            scnt_q    <= scnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Tap select as a compare-mux so the delay value never indexes past the line.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            tap[i] = 1'b0;
            for (int k = 0; k < MAX_DLY; k++) begin
                if (dly_q[i] == DW'(k + 1)) begin
                    tap[i] = sr_q[i][k];
                end
            end
        end
    end

    assign out       = &tap;
    assign out_valid = (scnt_q == '0) && !reset;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_path_delay_and.sv
// Directed bench for path_delay_and: default N_IN=4 instance plus an N_IN=6 instance
// for out-of-range index writes and high-side clamping.
module tb_path_delay_and;

    logic       clock;
    logic       reset;
    logic [3:0] in4;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [4:0] cfg_dly;
    logic       out;
    logic       out_valid;
    logic       cfg_err;

    logic       reset6;
    logic [5:0] in6;
    logic       cfg_we6;
    logic [2:0] cfg_idx6;
    logic [4:0] cfg_dly6;
    logic       out6;
    logic       valid6;
    logic       err6;

    int n_cmp;
    int n_bad;

    path_delay_and dut (
        .clock     (clock),
        .reset     (reset),
        .in        (in4),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_dly   (cfg_dly),
        .out       (out),
        .out_valid (out_valid),
        .cfg_err   (cfg_err)
    );

    path_delay_and #(.N_IN(6)) dut6 (
        .clock     (clock),
        .reset     (reset6),
        .in        (in6),
        .cfg_we    (cfg_we6),
        .cfg_idx   (cfg_idx6),
        .cfg_dly   (cfg_dly6),
        .out       (out6),
        .out_valid (valid6),
        .cfg_err   (err6)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int e, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @edge %0d: observed %0b expected %0b", tag, e, obs, exp);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        reset    = 1'b1;
        in4      = 4'b0000;
        cfg_we   = 1'b0;
        cfg_idx  = 2'd0;
        cfg_dly  = 5'd0;
        reset6   = 1'b1;
        in6      = 6'b000000;
        cfg_we6  = 1'b0;
        cfg_idx6 = 3'd0;
        cfg_dly6 = 5'd0;

        // Reset state
        repeat (3) tick();
        chk("rst_out",   -1, out,       1'b0);
        chk("rst_valid", -1, out_valid, 1'b0);
        chk("rst_err",   -1, cfg_err,   1'b0);
        reset = 1'b0;

        // Defaults 9/9/11/11; in[0] low at edges 5-9, in[3] low at edge 20
        for (int e = 0; e < 40; e++) begin
            in4 = 4'b1111;
            if (e >= 5 && e <= 9) in4[0] = 1'b0;
            if (e == 20) in4[3] = 1'b0;
            tick();
            chk("dflt_out",   e, out,       (e >= 10) && !(e >= 13 && e <= 17) && (e != 30));
            chk("dflt_valid", e, out_valid, e >= 10);
        end

        // Reprogram input 1 to 16 at edge 40
        for (int e = 40; e < 60; e++) begin
            in4     = 4'b1111;
            cfg_we  = (e == 40);
            cfg_idx = 2'd1;
            cfg_dly = 5'd16;
            tick();
            chk("rcfg_out",   e, out,       1'b1);
            chk("rcfg_valid", e, out_valid, e >= 55);
            chk("rcfg_err",   e, cfg_err,   1'b0);
        end
        cfg_we = 1'b0;

        // Delay-16 path: in[1] low at edge 60 shows at edge 75
        for (int e = 60; e < 80; e++) begin
            in4 = 4'b1111;
            if (e == 60) in4[1] = 1'b0;
            tick();
            chk("d16_out",   e, out,       e != 75);
            chk("d16_valid", e, out_valid, 1'b1);
        end

        // Write delay 0 to input 2: clamps to 1; in[2] pulse at edge 85
        for (int e = 80; e < 100; e++) begin
            in4     = 4'b1111;
            cfg_we  = (e == 80);
            cfg_idx = 2'd2;
            cfg_dly = 5'd0;
            if (e == 85) in4[2] = 1'b0;
            tick();
            chk("clamp_out",   e, out,       e != 85);
            chk("clamp_valid", e, out_valid, e >= 95);
        end
        cfg_we = 1'b0;

        // Reset together with a write of 16 to input 0: the write must be lost
        in4     = 4'b1111;
        reset   = 1'b1;
        cfg_we  = 1'b1;
        cfg_idx = 2'd0;
        cfg_dly = 5'd16;
        tick();
        chk("mrst_out",   100, out,       1'b0);
        chk("mrst_valid", 100, out_valid, 1'b0);
        chk("mrst_err",   100, cfg_err,   1'b0);
        reset  = 1'b0;
        cfg_we = 1'b0;

        // Delays back to 9/9/11/11: in[0] pulse at 4 -> 12, in[2] pulse at 6 -> 16
        for (int e = 0; e < 20; e++) begin
            in4 = 4'b1111;
            if (e == 4) in4[0] = 1'b0;
            if (e == 6) in4[2] = 1'b0;
            tick();
            chk("post_out",   e, out,       (e >= 10) && (e != 12) && (e != 16));
            chk("post_valid", e, out_valid, e >= 10);
        end

        // Six-input instance: reset state
        chk("n6_rst_out",   -1, out6,   1'b0);
        chk("n6_rst_valid", -1, valid6, 1'b0);
        chk("n6_rst_err",   -1, err6,   1'b0);
        reset6 = 1'b0;

        // idx 7 write at edge 11 (error only), idx 0 <- 31 at edge 13 (clamps to 16),
        // in[0] pulse at edge 14 -> edge 29; tap reads reset zeros at edges 13-14
        for (int e = 0; e < 31; e++) begin
            in6      = 6'b111111;
            cfg_we6  = (e == 11) || (e == 13);
            cfg_idx6 = (e == 11) ? 3'd7 : 3'd0;
            cfg_dly6 = (e == 11) ? 5'd1 : 5'd31;
            if (e == 14) in6[0] = 1'b0;
            tick();
            chk("n6_out",   e, out6,   (e >= 10) && (e != 13) && (e != 14) && (e != 29));
            chk("n6_valid", e, valid6, ((e >= 10) && (e < 13)) || (e >= 28));
            chk("n6_err",   e, err6,   e == 11);
        end
        cfg_we6 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
